// File: rtl/trace_buffer.sv
// trace_buffer: captures retired register-file writes into a first-word fall-through FIFO and flags any dropped captures.
// Optional macro TRACE_BUFFER_DROP_COUNT_EN adds a saturating 16-bit drop_count output.
module trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            debug_program_count,
  input  logic [3:0]             debug_register_file_write_enabled,
  input  logic [4:0]             debug_register_file_write_address,
  input  logic [31:0]            debug_register_file_write_data,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [31:0]            trace_program_count,
  output logic [3:0]             trace_write_strobe,
  output logic [4:0]             trace_address,
  output logic [31:0]            trace_data,
  output logic [COUNT_WIDTH-1:0] trace_count,
  output logic                   overflow,
  input  logic                   overflow_clear
`ifdef TRACE_BUFFER_DROP_COUNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  localparam int PTR_WIDTH   = $clog2(DEPTH);
  localparam int ENTRY_WIDTH = 73;
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

  logic [ENTRY_WIDTH-1:0] entry_mem [DEPTH];
  logic [ENTRY_WIDTH-1:0] head_entry;
  logic [PTR_WIDTH-1:0]   read_ptr_reg;
  logic [PTR_WIDTH-1:0]   write_ptr_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   overflow_reg;
  logic                   overflow_next;
  logic                   capture;
  logic                   pop;
  logic                   push;
  logic                   drop;

  assign capture = |debug_register_file_write_enabled;
  assign pop     = (count_reg != '0) && trace_ready;
  // A pop at full frees the slot in the same cycle, so the capture is still accepted.
  assign push    = capture && ((count_reg != FULL_COUNT) || pop);
  assign drop    = capture && (count_reg == FULL_COUNT) && !pop;

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + COUNT_WIDTH'(1);
      2'b01:   count_next = count_reg - COUNT_WIDTH'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    overflow_next = overflow_reg;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (overflow_clear) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_ptr_reg  <= '0;
      write_ptr_reg <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      if (push) begin
        write_ptr_reg <= write_ptr_reg + PTR_WIDTH'(1);
      end
      if (pop) begin
        read_ptr_reg <= read_ptr_reg + PTR_WIDTH'(1);
      end
    end
  end

  // Storage is not reset; only pointers and occupancy define which entries are live.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      entry_mem[write_ptr_reg] <= {debug_program_count,
                                   debug_register_file_write_enabled,
                                   debug_register_file_write_address,
                                   debug_register_file_write_data};
    end
  end

  // Head fields depend only on stored state, never on trace_ready.
  assign head_entry          = entry_mem[read_ptr_reg];
  assign trace_program_count = head_entry[72:41];
  assign trace_write_strobe  = head_entry[40:37];
  assign trace_address       = head_entry[36:32];
  assign trace_data          = head_entry[31:0];
  assign trace_valid         = (count_reg != '0);
  assign trace_count         = count_reg;
  assign overflow            = overflow_reg;

`ifdef TRACE_BUFFER_DROP_COUNT_EN
  logic [15:0] drop_count_reg;
  logic [15:0] drop_count_next;

  always_comb begin
    drop_count_next = drop_count_reg;
    if (drop) begin
      if (overflow_clear) begin
        drop_count_next = 16'd1;
      end else if (drop_count_reg != 16'hFFFF) begin
        drop_count_next = drop_count_reg + 16'd1;
      end
    end else if (overflow_clear) begin
      drop_count_next = 16'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count_reg <= 16'd0;
    end else begin
      drop_count_reg <= drop_count_next;
    end
  end

  assign drop_count = drop_count_reg;
`endif

endmodule
